sd_cmd_seq: RTL and testbench
=============================

Name: sd_cmd_seq

Overview:
Command sequencer that sits directly upstream of the SD command-line controller and drives its start/cmd/arg/precnt/clkdiv inputs.
- After reset or `reinit`, it runs SD-mode card identification: CMD0, CMD8, CMD55/ACMD41 loop, CMD2, CMD3, CMD7, and CMD16 (SDSC only).
- It then switches the SD clock to the fast divider and issues CMD17 single-block reads on request.
- It reports card type, RCA, and error status to the sector-read/data-path logic.

Parameters:
- SLOW_CLKDIV, 16'd50: clkdiv used during identification (≤400 kHz).
- FAST_CLKDIV, 16'd1: clkdiv used after CMD3 succeeds.
- INIT_PRECNT, 16'd80: idle sdclk count before CMD0 (≥74 required).
- CMD_PRECNT, 16'd8: idle sdclk count before every other command.
- ACMD41_TRIES, 16'd2000: maximum CMD55/ACMD41 iterations.

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous, active-low reset
- reinit  in  1  one-cycle pulse; restarts identification from CMD0
- ctrl_start  out  1  start pulse to command controller
- ctrl_precnt  out  16  pre-command idle clock count
- ctrl_cmd  out  6  command index
- ctrl_arg  out  32  command argument
- ctrl_clkdiv  out  16  SD clock divider
- ctrl_busy  in  1  controller busy
- ctrl_done  in  1  controller one-cycle completion pulse
- ctrl_timeout  in  1  no response (valid with done)
- ctrl_syntaxe  in  1  response start/index error (valid with done)
- ctrl_resparg  in  32  response argument (valid with done)
- card_ready  out  1  identification complete
- card_type  out  2  0 none, 1 SDv1, 2 SDv2 SDSC, 3 SDHC/SDXC
- rca  out  16  relative card address
- init_err  out  4  sticky error code, 0 = none
- rd_req  in  1  read request, sampled only when card_ready and seq idle
- rd_sector  in  32  sector number, captured with rd_req
- rd_ack  out  1  one-cycle pulse: CMD17 finished
- rd_ok  out  1  valid with rd_ack: R1 accepted

Behaviour:
Reset values: ctrl_start 0, ctrl_precnt 0, ctrl_cmd 0, ctrl_arg 0, ctrl_clkdiv SLOW_CLKDIV, card_ready 0, card_type 0, rca 0, init_err 0, rd_ack 0, rd_ok 0. Exit from reset goes to ISSUE CMD0.

Issue handshake (all commands):
- ctrl_cmd/arg/precnt are registered in the same cycle ctrl_start=1, held 1 cycle, and held stable until done.
- Start is asserted only when ctrl_busy=0, and never in the cycle of ctrl_done or the cycle after, because busy drops one cycle after done.
- State then goes to WAIT, which watches only ctrl_done, not busy.

Per-command result rules (applied in the ctrl_done cycle):
- CMD0, arg 0, INIT_PRECNT: result ignored (timeout expected) → CMD8.
- CMD8, arg 0x000001AA:
  - timeout → card_type=1 (SDv1) → CMD55.
  - !syntaxe and resparg[11:0]==12'h1AA → provisional v2 → CMD55.
  - otherwise err=1.
- CMD55, arg {rca,16'h0} (rca=0 during init): timeout or syntaxe → err=2.
- ACMD41, cmd 41:
  - arg 0xC0100000 if v2, else 0x00100000. Syntaxe is ignored (R3).
  - resparg[31]=1 → if v2, card_type = resparg[30] ? 3 : 2 → CMD2.
  - Otherwise increment the try counter and loop to CMD55. Reaching ACMD41_TRIES → err=3.
  - timeout → err=3.
- CMD2, arg 0: timeout → err=4. Syntaxe ignored (R2 long response).
- CMD3, arg 0: timeout/syntaxe → err=5; else rca=resparg[31:16], ctrl_clkdiv=FAST_CLKDIV.
- CMD7, arg {rca,16'h0}: timeout/syntaxe → err=6.
- CMD16, arg 512: issued only for card_type 1 or 2. Timeout/syntaxe → err=7.
- Success → card_ready=1 → READY.

Error handling:
- ERROR: init_err holds the code; card_ready=0; ctrl_clkdiv unchanged; rd_req ignored.
- reinit in any state, including WAIT: the pending done is discarded; card_ready, card_type, rca, init_err are cleared; ctrl_clkdiv=SLOW_CLKDIV; the try counter is cleared; go to ISSUE CMD0 once ctrl_busy=0.

READY reads:
- rd_req → CMD17, arg = (card_type==3) ? rd_sector : rd_sector<<9 (32-bit, upper bits discarded).
- On done: rd_ack=1 for 1 cycle; rd_ok = !timeout && !syntaxe && resparg[31:19]==0.
- Return to READY. rd_req during a read in flight is ignored.

Counter widths: try counter 16 bits, no wrap; the compare happens before increment.

Test Plan:
- SDHC model (CMD0 timeout, CMD8 echo 1AA, ACMD41 busy twice then 0xC0FF8000, CMD3 rca 0x1234) → sequence 0,8,55,41,55,41,55,41,2,3,7; card_type=3, rca=0x1234, card_ready=1, clkdiv=1 after CMD3, no CMD16.
- SDv1 model (CMD8 timeout, ACMD41 ready 0x80FF8000) → ACMD41 arg 0x00100000, CMD16 arg 512 issued, card_type=1.
- ACMD41 never ready → exactly 2000 ACMD41s, then init_err=3, card_ready=0; rd_req produces no start.
- READY, SDSC, rd_sector=0x10 → CMD17 arg 0x2000, rd_ack pulse with rd_ok=1. SDHC → arg 0x10. Response resparg=0x00080000 → rd_ok=0.
- reinit asserted while CMD7 in flight → done ignored; clkdiv back to 50; next start is CMD0 with precnt 80; outputs cleared.
- Back-to-back check: no ctrl_start while ctrl_busy=1 or within 2 cycles after ctrl_done, across the whole init run.

Source files
------------

// File: rtl/sd_cmd_seq.sv
// rtl/sd_cmd_seq.sv - SD-mode card identification and CMD17 read sequencer
module sd_cmd_seq #(
  parameter logic [15:0] SLOW_CLKDIV  = 16'd50,
  parameter logic [15:0] FAST_CLKDIV  = 16'd1,
  parameter logic [15:0] INIT_PRECNT  = 16'd80,
  parameter logic [15:0] CMD_PRECNT   = 16'd8,
  parameter logic [15:0] ACMD41_TRIES = 16'd2000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        reinit,
  output logic        ctrl_start,
  output logic [15:0] ctrl_precnt,
  output logic [5:0]  ctrl_cmd,
  output logic [31:0] ctrl_arg,
  output logic [15:0] ctrl_clkdiv,
  input  logic        ctrl_busy,
  input  logic        ctrl_done,
  input  logic        ctrl_timeout,
  input  logic        ctrl_syntaxe,
  input  logic [31:0] ctrl_resparg,
  output logic        card_ready,
  output logic [1:0]  card_type,
  output logic [15:0] rca,
  output logic [3:0]  init_err,
  input  logic        rd_req,
  input  logic [31:0] rd_sector,
  output logic        rd_ack,
  output logic        rd_ok
);

  typedef enum logic [1:0] {ST_ISSUE, ST_WAIT, ST_READY, ST_ERROR} state_t;

  state_t      state_q, state_d;
  logic [5:0]  ncmd_q, ncmd_d, cmd_q, cmd_d;
  logic [31:0] arg_q, arg_d, rd_arg_q, rd_arg_d, arg_sel;
  logic [15:0] precnt_q, precnt_d, clkdiv_q, clkdiv_d, rca_q, rca_d, tries_q, tries_d;
  logic [1:0]  type_q, type_d;
  logic [3:0]  err_q, err_d;
  logic        start_q, start_d, ready_q, ready_d, v2_q, v2_d;
  logic        rd_ack_q, rd_ack_d, rd_ok_q, rd_ok_d, done_d1_q, done_d1_d;
  logic        issue_ok, resp_bad;

  // R1/R6 status bits between the RCA and the echo pattern carry nothing we act on
  logic unused_resp;
  assign unused_resp = ^ctrl_resparg[15:12];

  assign ctrl_start  = start_q;
  assign ctrl_precnt = precnt_q;
  assign ctrl_cmd    = cmd_q;
  assign ctrl_arg    = arg_q;
  assign ctrl_clkdiv = clkdiv_q;
  assign card_ready  = ready_q;
  assign card_type   = type_q;
  assign rca         = rca_q;
  assign init_err    = err_q;
  assign rd_ack      = rd_ack_q;
  assign rd_ok       = rd_ok_q;

  // Busy only drops the cycle after done, so the done cycle and the one after are blocked too
  assign issue_ok = !ctrl_busy && !ctrl_done && !done_d1_q;
  assign resp_bad = ctrl_timeout || ctrl_syntaxe;

  // Argument for the next command to be issued
  always_comb begin
    arg_sel = 32'h0;
    case (ncmd_q)
      6'd8:        arg_sel = 32'h0000_01AA;
      6'd55, 6'd7: arg_sel = {rca_q, 16'h0};
      6'd41:       arg_sel = v2_q ? 32'hC010_0000 : 32'h0010_0000;
      6'd16:       arg_sel = 32'd512;
      6'd17:       arg_sel = rd_arg_q;
      default:     arg_sel = 32'h0;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_ISSUE;
      ncmd_q    <= 6'd0;
      cmd_q     <= 6'd0;
      arg_q     <= 32'h0;
      rd_arg_q  <= 32'h0;
      precnt_q  <= 16'h0;
      clkdiv_q  <= SLOW_CLKDIV;
      rca_q     <= 16'h0;
      tries_q   <= 16'h0;
      type_q    <= 2'd0;
      err_q     <= 4'd0;
      start_q   <= 1'b0;
      ready_q   <= 1'b0;
      v2_q      <= 1'b0;
      rd_ack_q  <= 1'b0;
      rd_ok_q   <= 1'b0;
      done_d1_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ncmd_q    <= ncmd_d;
      cmd_q     <= cmd_d;
      arg_q     <= arg_d;
      rd_arg_q  <= rd_arg_d;
      precnt_q  <= precnt_d;
      clkdiv_q  <= clkdiv_d;
      rca_q     <= rca_d;
      tries_q   <= tries_d;
      type_q    <= type_d;
      err_q     <= err_d;
      start_q   <= start_d;
      ready_q   <= ready_d;
      v2_q      <= v2_d;
      rd_ack_q  <= rd_ack_d;
      rd_ok_q   <= rd_ok_d;
      done_d1_q <= done_d1_d;
    end
  end

  // Sequencing: issue a command, then judge its response on done
  always_comb begin
    state_d   = state_q;
    ncmd_d    = ncmd_q;
    cmd_d     = cmd_q;
    arg_d     = arg_q;
    rd_arg_d  = rd_arg_q;
    precnt_d  = precnt_q;
    clkdiv_d  = clkdiv_q;
    rca_d     = rca_q;
    tries_d   = tries_q;
    type_d    = type_q;
    err_d     = err_q;
    start_d   = 1'b0;
    ready_d   = ready_q;
    v2_d      = v2_q;
    rd_ack_d  = 1'b0;
    rd_ok_d   = rd_ok_q;
    done_d1_d = ctrl_done;

    if (reinit) begin
      state_d  = ST_ISSUE;
      ncmd_d   = 6'd0;
      ready_d  = 1'b0;
      type_d   = 2'd0;
      v2_d     = 1'b0;
      rca_d    = 16'h0;
      err_d    = 4'd0;
      tries_d  = 16'h0;
      clkdiv_d = SLOW_CLKDIV;
    end else begin
      case (state_q)
        ST_ISSUE: begin
          if (issue_ok) begin
            start_d  = 1'b1;
            cmd_d    = ncmd_q;
            arg_d    = arg_sel;
            precnt_d = (ncmd_q == 6'd0) ? INIT_PRECNT : CMD_PRECNT;
            state_d  = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (ctrl_done) begin
            state_d = ST_ISSUE;
            case (cmd_q)
              6'd0: ncmd_d = 6'd8;
              6'd8: begin
                if (ctrl_timeout) begin
                  type_d = 2'd1;
                  v2_d   = 1'b0;
                  ncmd_d = 6'd55;
                end else if (!ctrl_syntaxe && ctrl_resparg[11:0] == 12'h1AA) begin
                  v2_d   = 1'b1;
                  ncmd_d = 6'd55;
                end else begin
                  err_d = 4'd1; state_d = ST_ERROR;
                end
              end
              6'd55: begin
                if (resp_bad) begin err_d = 4'd2; state_d = ST_ERROR; end
                else ncmd_d = 6'd41;
              end
              6'd41: begin
                if (ctrl_timeout) begin
                  err_d = 4'd3; state_d = ST_ERROR;
                end else if (ctrl_resparg[31]) begin
                  if (v2_q) type_d = ctrl_resparg[30] ? 2'd3 : 2'd2;
                  ncmd_d = 6'd2;
                end else if (tries_q == ACMD41_TRIES - 16'd1) begin
                  err_d = 4'd3; state_d = ST_ERROR;
                end else begin
                  tries_d = tries_q + 16'd1;
                  ncmd_d  = 6'd55;
                end
              end
              6'd2: begin
                if (ctrl_timeout) begin err_d = 4'd4; state_d = ST_ERROR; end
                else ncmd_d = 6'd3;
              end
              6'd3: begin
                if (resp_bad) begin
                  err_d = 4'd5; state_d = ST_ERROR;
                end else begin
                  rca_d    = ctrl_resparg[31:16];
                  clkdiv_d = FAST_CLKDIV;
                  ncmd_d   = 6'd7;
                end
              end
              6'd7: begin
                if (resp_bad) begin
                  err_d = 4'd6; state_d = ST_ERROR;
                end else if (type_q == 2'd1 || type_q == 2'd2) begin
                  ncmd_d = 6'd16;
                end else begin
                  ready_d = 1'b1; state_d = ST_READY;
                end
              end
              6'd16: begin
                if (resp_bad) begin err_d = 4'd7; state_d = ST_ERROR; end
                else begin ready_d = 1'b1; state_d = ST_READY; end
              end
              default: begin
                rd_ack_d = 1'b1;
                rd_ok_d  = !resp_bad && (ctrl_resparg[31:19] == 13'h0);
                state_d  = ST_READY;
              end
            endcase
          end
        end
        ST_READY: begin
          if (rd_req) begin
            rd_arg_d = (type_q == 2'd3) ? rd_sector : (rd_sector << 9);
            ncmd_d   = 6'd17;
            state_d  = ST_ISSUE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_cmd_seq.sv
// tb/tb_sd_cmd_seq.sv - scoreboard bench for sd_cmd_seq with a behavioural controller/card
module tb_sd_cmd_seq;

  logic        clk = 1'b0, rstn = 1'b0, reinit = 1'b0;
  logic        ctrl_start, card_ready, rd_ack, rd_ok;
  logic [15:0] ctrl_precnt, ctrl_clkdiv, rca;
  logic [5:0]  ctrl_cmd;
  logic [31:0] ctrl_arg;
  logic [1:0]  card_type;
  logic [3:0]  init_err;
  logic        ctrl_busy = 1'b0, ctrl_done = 1'b0, ctrl_timeout = 1'b0, ctrl_syntaxe = 1'b0;
  logic [31:0] ctrl_resparg = 32'h0;
  logic        rd_req = 1'b0;
  logic [31:0] rd_sector = 32'h0;

  sd_cmd_seq dut (
    .clk(clk), .rstn(rstn), .reinit(reinit),
    .ctrl_start(ctrl_start), .ctrl_precnt(ctrl_precnt), .ctrl_cmd(ctrl_cmd),
    .ctrl_arg(ctrl_arg), .ctrl_clkdiv(ctrl_clkdiv), .ctrl_busy(ctrl_busy),
    .ctrl_done(ctrl_done), .ctrl_timeout(ctrl_timeout), .ctrl_syntaxe(ctrl_syntaxe),
    .ctrl_resparg(ctrl_resparg), .card_ready(card_ready), .card_type(card_type),
    .rca(rca), .init_err(init_err), .rd_req(rd_req), .rd_sector(rd_sector),
    .rd_ack(rd_ack), .rd_ok(rd_ok)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic [5:0]  cmd;
    logic [31:0] arg;
    logic [15:0] precnt;
    logic [15:0] clkdiv;
  } exp_t;

  exp_t        expq[$];
  bit          rdq[$];
  exp_t        e;
  int          n_cmp = 0, n_bad = 0;
  int          cyc = 0, last_done = -100, cnt = 0, n_starts = 0, n41 = 0, acnt = 0;
  int          mode = 0;          // 0 SDHC, 1 SDv1, 2 ACMD41 never ready
  logic [31:0] rd_resp = 32'h900;
  logic        p_tmo, p_syn;
  logic [31:0] p_resp;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [5:0] c, input logic [31:0] a, input logic [15:0] p, input logic [15:0] d);
    exp_t x;
    x.cmd = c; x.arg = a; x.precnt = p; x.clkdiv = d;
    expq.push_back(x);
  endtask

  // Card behaviour chosen when the command is started
  task automatic respond(input logic [5:0] c);
    p_tmo = 1'b0; p_syn = 1'b0; p_resp = 32'h900;
    case (c)
      6'd0:  p_tmo = 1'b1;
      6'd8:  if (mode == 1) p_tmo = 1'b1; else p_resp = 32'h1AA;
      6'd55: p_resp = 32'h120;
      6'd41: begin
        p_syn = 1'b1;
        if (mode == 1) p_resp = 32'h80FF_8000;
        else if (mode == 0 && acnt >= 2) p_resp = 32'hC0FF_8000;
        else p_resp = 32'h00FF_8000;
        acnt++;
      end
      6'd2:  begin p_syn = 1'b1; p_resp = 32'h0; end
      6'd3:  p_resp = 32'h1234_0500;
      6'd17: p_resp = rd_resp;
      default: p_resp = 32'h900;
    endcase
  endtask

  // Controller model plus start/ack monitor
  initial begin
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (rd_ack) begin
        check("rd_ack_expected", rdq.size() != 0, 1);
        if (rdq.size() != 0) check("rd_ok", rd_ok, rdq.pop_front());
      end
      if (ctrl_start) begin
        check("start_gap_after_done", (cyc - last_done) > 2, 1);
        check("start_while_busy", ctrl_busy, 0);
        check("start_expected", expq.size() != 0, 1);
        if (expq.size() != 0) begin
          e = expq.pop_front();
          check("cmd", ctrl_cmd, e.cmd);
          check("arg", ctrl_arg, e.arg);
          check("precnt", ctrl_precnt, e.precnt);
          check("clkdiv", ctrl_clkdiv, e.clkdiv);
        end
        n_starts++;
        if (ctrl_cmd == 6'd41) n41++;
        respond(ctrl_cmd);
        ctrl_busy = 1'b1;
        cnt = 2;
      end else if (ctrl_done) begin
        ctrl_done = 1'b0;
        ctrl_busy = 1'b0;
      end else if (ctrl_busy) begin
        cnt--;
        if (cnt == 0) begin
          ctrl_done = 1'b1;
          ctrl_timeout = p_tmo;
          ctrl_syntaxe = p_syn;
          ctrl_resparg = p_resp;
          last_done = cyc;
        end
      end
    end
  end

  // which: 0 init settled, 1 last expected command in flight, 2 read finished
  task automatic wait_cond(input string tag, input int which, input int budget);
    bit ok;
    ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(posedge clk); #2;
      case (which)
        0: ok = (expq.size() == 0) && (card_ready || init_err != 4'd0);
        1: ok = (expq.size() == 0) && ctrl_busy;
        default: ok = (expq.size() == 0) && (rdq.size() == 0) && !ctrl_busy;
      endcase
    end
    check({tag, "_reached"}, ok, 1);
  endtask

  task automatic pulse_reinit();
    @(posedge clk); #2 reinit = 1'b1;
    @(posedge clk); #2 reinit = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] sec, input logic [31:0] exp_arg, input logic [31:0] resp, input bit exp_ok);
    rd_resp = resp;
    rd_sector = sec;
    push(6'd17, exp_arg, 16'd8, 16'd1);
    rdq.push_back(exp_ok);
    @(posedge clk); #2 rd_req = 1'b1;
    @(posedge clk); #2 rd_req = 1'b0;
    wait_cond("read", 2, 200);
  endtask

  task automatic push_sdhc();
    push(6'd0, 32'h0, 16'd80, 16'd50);
    push(6'd8, 32'h1AA, 16'd8, 16'd50);
    for (int i = 0; i < 3; i++) begin
      push(6'd55, 32'h0, 16'd8, 16'd50);
      push(6'd41, 32'hC010_0000, 16'd8, 16'd50);
    end
    push(6'd2, 32'h0, 16'd8, 16'd50);
    push(6'd3, 32'h0, 16'd8, 16'd50);
    push(6'd7, 32'h1234_0000, 16'd8, 16'd1);
  endtask

  initial begin
    int s0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_start", ctrl_start, 0);
    check("rst_precnt", ctrl_precnt, 0);
    check("rst_cmd", ctrl_cmd, 0);
    check("rst_arg", ctrl_arg, 0);
    check("rst_clkdiv", ctrl_clkdiv, 16'd50);
    check("rst_ready", card_ready, 0);
    check("rst_type", card_type, 0);
    check("rst_rca", rca, 0);
    check("rst_err", init_err, 0);
    check("rst_rd_ack", rd_ack, 0);
    check("rst_rd_ok", rd_ok, 0);

    // SDHC identification
    mode = 0; acnt = 0;
    push_sdhc();
    rstn = 1'b1;
    wait_cond("sdhc_init", 0, 2000);
    check("sdhc_ready", card_ready, 1);
    check("sdhc_type", card_type, 3);
    check("sdhc_rca", rca, 16'h1234);
    check("sdhc_clkdiv", ctrl_clkdiv, 16'd1);
    check("sdhc_err", init_err, 0);
    repeat (20) @(posedge clk);
    check("sdhc_no_cmd16", expq.size(), 0);

    // SDHC reads: block addressing, then an R1 error bit
    do_read(32'h10, 32'h10, 32'h900, 1'b1);
    do_read(32'h10, 32'h10, 32'h0008_0000, 1'b0);

    // SDv1 identification and byte-addressed read
    mode = 1; acnt = 0;
    push(6'd0, 32'h0, 16'd80, 16'd50);
    push(6'd8, 32'h1AA, 16'd8, 16'd50);
    push(6'd55, 32'h0, 16'd8, 16'd50);
    push(6'd41, 32'h0010_0000, 16'd8, 16'd50);
    push(6'd2, 32'h0, 16'd8, 16'd50);
    push(6'd3, 32'h0, 16'd8, 16'd50);
    push(6'd7, 32'h1234_0000, 16'd8, 16'd1);
    push(6'd16, 32'd512, 16'd8, 16'd1);
    pulse_reinit();
    wait_cond("v1_init", 0, 2000);
    check("v1_ready", card_ready, 1);
    check("v1_type", card_type, 1);
    do_read(32'h10, 32'h2000, 32'h900, 1'b1);

    // reinit while CMD7 is in flight
    mode = 0; acnt = 0;
    push_sdhc();
    pulse_reinit();
    wait_cond("cmd7_inflight", 1, 2000);
    push_sdhc();
    pulse_reinit();
    check("reinit_ready", card_ready, 0);
    check("reinit_type", card_type, 0);
    check("reinit_rca", rca, 0);
    check("reinit_err", init_err, 0);
    check("reinit_clkdiv", ctrl_clkdiv, 16'd50);
    acnt = 0;
    wait_cond("reinit_init", 0, 2000);
    check("reinit_final_ready", card_ready, 1);
    check("reinit_final_type", card_type, 3);

    // ACMD41 never ready
    mode = 2; acnt = 0;
    push(6'd0, 32'h0, 16'd80, 16'd50);
    push(6'd8, 32'h1AA, 16'd8, 16'd50);
    for (int i = 0; i < 2000; i++) begin
      push(6'd55, 32'h0, 16'd8, 16'd50);
      push(6'd41, 32'hC010_0000, 16'd8, 16'd50);
    end
    pulse_reinit();
    n41 = 0;
    wait_cond("acmd41_limit", 0, 40000);
    check("limit_err", init_err, 3);
    check("limit_ready", card_ready, 0);
    check("limit_n41", n41, 2000);
    s0 = n_starts;
    @(posedge clk); #2 rd_req = 1'b1;
    @(posedge clk); #2 rd_req = 1'b0;
    repeat (50) @(posedge clk);
    check("error_ignores_rd_req", n_starts, s0);
    check("error_err_held", init_err, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
